// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: synchronises SDA/SCL, matches a 7-bit
// address and hands data bytes to a one-entry valid/ready holding register.
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_first,
  output logic       frame_end,
  output logic       busy,
  output logic       overrun
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_ACK  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_NACK = 3'd4;
  localparam logic [2:0] ST_IGN  = 3'd5;

  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic r_sda_d;
  logic r_scl_d;

  logic [2:0] r_state;
  logic [2:0] r_bcnt;
  logic [6:0] r_shift;
  logic       r_ack_fall;
  logic       r_ack_addr;
  logic       r_first_flag;
  logic       r_sda_oe;
  logic       r_busy;
  logic       r_frame_end;
  logic       r_overrun;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_rx_first;

  logic       w_sda_s;
  logic       w_scl_s;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;
  logic       w_last_bit;
  logic       w_xfer;
  logic       w_load;

  assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl_s & ~r_scl_d;
  assign w_scl_fall = ~w_scl_s & r_scl_d;
  assign w_start    = w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
  assign w_stop     = w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;
  assign w_byte     = {r_shift, w_sda_s};
  assign w_last_bit = w_scl_rise & (r_bcnt == 3'd7);
  assign w_xfer     = r_rx_valid & rx_ready;
  assign w_load     = (r_state == ST_DATA) & w_last_bit & ~w_start
                    & ~w_stop & (~r_rx_valid | rx_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sda_sync <= '1;
      r_scl_sync <= '1;
      r_sda_d    <= 1'b1;
      r_scl_d    <= 1'b1;
    end else begin
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_d    <= w_sda_s;
      r_scl_d    <= w_scl_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_bcnt       <= 3'd0;
      r_shift      <= 7'd0;
      r_ack_fall   <= 1'b0;
      r_ack_addr   <= 1'b0;
      r_first_flag <= 1'b0;
      r_sda_oe     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_end  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_end <= 1'b0;
      if (w_start || w_stop) begin
        r_state     <= w_start ? ST_ADDR : ST_IDLE;
        r_bcnt      <= 3'd0;
        r_sda_oe    <= 1'b0;
        r_busy      <= 1'b0;
        r_frame_end <= r_busy;
      end else begin
        case (r_state)
          ST_ADDR: if (w_scl_rise) begin
            r_shift <= w_byte[6:0];
            r_bcnt  <= r_bcnt + 3'd1;
            if (r_bcnt == 3'd7) begin
              if (w_byte[7:1] == TARGET_ADDR && !w_byte[0]) begin
                r_state      <= ST_ACK;
                r_ack_addr   <= 1'b1;
                r_ack_fall   <= 1'b0;
                r_first_flag <= 1'b1;
              end else begin
                r_state <= ST_IGN;
              end
            end
          end
          ST_ACK: if (w_scl_fall) begin
            if (!r_ack_fall) begin
              r_ack_fall <= 1'b1;
              r_sda_oe   <= 1'b1;
            end else begin
              r_sda_oe <= 1'b0;
              r_state  <= ST_DATA;
              r_bcnt   <= 3'd0;
              if (r_ack_addr) r_busy <= 1'b1;
            end
          end
          ST_DATA: if (w_scl_rise) begin
            r_shift <= w_byte[6:0];
            r_bcnt  <= r_bcnt + 3'd1;
            if (r_bcnt == 3'd7) begin
              r_ack_fall <= 1'b0;
              r_ack_addr <= 1'b0;
              if (w_load) begin
                r_state      <= ST_ACK;
                r_first_flag <= 1'b0;
              end else begin
                r_state   <= ST_NACK;
                r_overrun <= 1'b1;
              end
            end
          end
          ST_NACK: if (w_scl_fall) begin
            if (!r_ack_fall) r_ack_fall <= 1'b1;
            else             r_state    <= ST_IGN;
          end
          default: ;
        endcase
      end
    end
  end

  // Holding register: a load wins over a same-cycle transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_rx_first <= 1'b0;
    end else if (w_load) begin
      r_rx_data  <= w_byte;
      r_rx_valid <= 1'b1;
      r_rx_first <= r_first_flag;
    end else if (w_xfer) begin
      r_rx_valid <= 1'b0;
      r_rx_first <= 1'b0;
    end
  end

  assign sda_oe    = r_sda_oe;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_first  = r_rx_first;
  assign frame_end = r_frame_end;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: table of single-byte frames plus
// hand-written overrun, repeated-START and mid-frame reset sequences.
module tb_i2c_target_rx;

  logic       clk;
  logic       rst;
  logic       r_sda;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_first;
  logic       frame_end;
  logic       busy;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  logic [8:0] rxq[$];

  // open-drain bus: target pulls low when sda_oe=1
  assign sda_in = r_sda & ~sda_oe;

  i2c_target_rx dut (
    .clk(clk), .rst(rst), .sda_in(sda_in), .scl_in(scl_in),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_first(rx_first), .frame_end(frame_end),
    .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_end) fe_cnt++;
    if (rx_valid && rx_ready) rxq.push_back({rx_first, rx_data});
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n * 8) @(negedge clk);
  endtask

  task automatic i2c_start();
    r_sda = 1'b0; wq(2);
    scl_in = 1'b0; wq(1);
  endtask

  task automatic i2c_rstart();
    r_sda = 1'b1; wq(1);
    scl_in = 1'b1; wq(1);
    r_sda = 1'b0; wq(1);
    scl_in = 1'b0; wq(1);
  endtask

  task automatic i2c_stop();
    r_sda = 1'b0; wq(1);
    scl_in = 1'b1; wq(1);
    r_sda = 1'b1; wq(2);
  endtask

  task automatic i2c_bit(input logic b);
    r_sda = b; wq(1);
    scl_in = 1'b1; wq(2);
    scl_in = 1'b0; wq(1);
  endtask

  task automatic i2c_byte(input logic [7:0] b, output logic [1:0] ack);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    r_sda = 1'b1; wq(1);
    ack[1] = sda_oe;
    scl_in = 1'b1; wq(1);
    ack[0] = sda_oe;
    wq(1);
    scl_in = 1'b0; wq(1);
  endtask

  typedef struct {
    logic [7:0] abyte;
    logic [7:0] dbyte;
    logic [1:0] eack_a;
    logic [1:0] eack_d;
    int         efe;
    int         en;
  } vec_t;

  vec_t tv[6];
  logic [1:0] ack;
  int fe0;

  initial begin
    tv[0] = '{8'h84, 8'hA5, 2'b11, 2'b11, 1, 1};
    tv[1] = '{8'h86, 8'hFF, 2'b00, 2'b00, 0, 0};
    tv[2] = '{8'h85, 8'h33, 2'b00, 2'b00, 0, 0};
    tv[3] = '{8'h84, 8'h00, 2'b11, 2'b11, 1, 1};
    tv[4] = '{8'h84, 8'hFF, 2'b11, 2'b11, 1, 1};
    tv[5] = '{8'h04, 8'h42, 2'b00, 2'b00, 0, 0};

    rst = 1'b1; r_sda = 1'b1; scl_in = 1'b1; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", {sda_oe, rx_data, rx_valid, rx_first,
        frame_end, busy, overrun}, 32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_outs", {sda_oe, rx_valid, frame_end, busy}, 32'd0);
    chk("idle_fe", fe_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      fe0 = fe_cnt;
      rxq.delete();
      i2c_start();
      i2c_byte(tv[i].abyte, ack);
      chk($sformatf("v%0d_addr_ack", i), ack, tv[i].eack_a);
      chk($sformatf("v%0d_busy", i), busy, tv[i].eack_a[0]);
      i2c_byte(tv[i].dbyte, ack);
      chk($sformatf("v%0d_data_ack", i), ack, tv[i].eack_d);
      i2c_stop();
      wq(2);
      chk($sformatf("v%0d_fe", i), fe_cnt - fe0, tv[i].efe);
      chk($sformatf("v%0d_nrx", i), rxq.size(), tv[i].en);
      if (rxq.size() == 1)
        chk($sformatf("v%0d_rx", i), rxq[0], {1'b1, tv[i].dbyte});
      chk($sformatf("v%0d_busy_end", i), busy, 0);
    end
    chk("no_overrun_yet", overrun, 0);

    // holding register full: second byte NACKed, third ignored
    rx_ready = 1'b0;
    rxq.delete();
    fe0 = fe_cnt;
    i2c_start();
    i2c_byte(8'h84, ack);
    chk("ovr_addr_ack", ack, 2'b11);
    i2c_byte(8'h11, ack);
    chk("ovr_b1_ack", ack, 2'b11);
    chk("ovr_b1_hold", {rx_valid, rx_first, rx_data}, {2'b11, 8'h11});
    i2c_byte(8'h22, ack);
    chk("ovr_b2_nack", ack, 2'b00);
    chk("ovr_flag", overrun, 1);
    i2c_byte(8'h33, ack);
    chk("ovr_b3_nack", ack, 2'b00);
    chk("ovr_b3_hold", {rx_valid, rx_data}, {1'b1, 8'h11});
    i2c_stop();
    wq(2);
    chk("ovr_fe", fe_cnt - fe0, 1);
    chk("ovr_no_xfer", rxq.size(), 0);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovr_drain_n", rxq.size(), 1);
    if (rxq.size() == 1) chk("ovr_drain", rxq[0], {1'b1, 8'h11});
    chk("ovr_valid_clr", rx_valid, 0);
    chk("ovr_sticky", overrun, 1);

    // repeated START ends the first frame
    rxq.delete();
    fe0 = fe_cnt;
    i2c_start();
    i2c_byte(8'h84, ack);
    i2c_byte(8'h10, ack);
    chk("rs_b1_ack", ack, 2'b11);
    i2c_rstart();
    chk("rs_fe_start", fe_cnt - fe0, 1);
    chk("rs_busy_clr", busy, 0);
    i2c_byte(8'h84, ack);
    chk("rs_addr2_ack", ack, 2'b11);
    i2c_byte(8'h20, ack);
    i2c_stop();
    wq(2);
    chk("rs_fe_total", fe_cnt - fe0, 2);
    chk("rs_nrx", rxq.size(), 2);
    if (rxq.size() == 2) begin
      chk("rs_rx0", rxq[0], {1'b1, 8'h10});
      chk("rs_rx1", rxq[1], {1'b1, 8'h20});
    end

    // reset during the address ACK low phase
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(1'(8'h84 >> i));
    r_sda = 1'b1; wq(1);
    chk("mr_oe_before", sda_oe, 1);
    rst = 1'b1;
    #1;
    chk("mr_oe_async", sda_oe, 0);
    repeat (3) @(negedge clk);
    chk("mr_outs", {busy, overrun, rx_valid}, 0);
    scl_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wq(2);
    rxq.delete();
    i2c_start();
    i2c_byte(8'h84, ack);
    chk("mr_addr_ack", ack, 2'b11);
    i2c_byte(8'h5A, ack);
    chk("mr_data_ack", ack, 2'b11);
    i2c_stop();
    wq(2);
    chk("mr_nrx", rxq.size(), 1);
    if (rxq.size() == 1) chk("mr_rx", rxq[0], {1'b1, 8'h5A});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- Write-only I2C target front end between the top-level pin wrapper and the canvas core.
- Takes the raw sda/scl from uio_in[0]/uio_in[1] and synchronises both lines.
- Detects START/STOP, matches a 7-bit address and deserialises data bytes into a one-entry valid/ready holding register.
- Drives an ACK/NACK open-drain enable, which the top maps onto uio_oe[0] with uio_out[0]=0.

Parameters:
- TARGET_ADDR, 7'h42, 7-bit I2C address this target answers to.
- SYNC_STAGES, 2, flip-flop stages on each of sda and scl (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 16x the SCL rate.
- rst  input  1  asynchronous, active-high reset.
- sda_in  input  1  raw SDA pin level.
- scl_in  input  1  raw SCL pin level.
- sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
- rx_data  output  8  received data byte, held stable while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts; a transfer happens when rx_valid and rx_ready are both 1.
- rx_first  output  1  qualifies rx_data: first data byte after an address match.
- frame_end  output  1  one-cycle pulse on STOP, or on repeated START, that ends an addressed frame.
- busy  output  1  high from an address match until STOP or START.
- overrun  output  1  sticky; a byte was NACKed because the holding register was full.

Behaviour:
Reset:
- All outputs are 0, state is IDLE, and the synchroniser flops preset to 1 (bus idle).

Synchronisation and edges:
- sda_s and scl_s are the last synchroniser stages; a one-cycle-delayed copy of each gives the edge signals.
- scl_rise = scl_s & !scl_d; scl_fall = !scl_s & scl_d.
- START = scl_s & scl_d & sda_d & !sda_s.
- STOP = scl_s & scl_d & !sda_d & sda_s.
- START and STOP take priority over every state. START goes to ADDR and clears the bit counter. STOP goes to IDLE.
- Either one releases sda_oe in the same cycle and clears busy.
- frame_end pulses if busy was 1.

States:
- IDLE: wait for START.
- ADDR: shift sda_s in MSB-first on each scl_rise, with bcnt counting 0..7. On the 8th rise, compare shift[7:1] with TARGET_ADDR and take shift[0] as R/W.
  - Match and W=0: ack_pending=1, go to ACK.
  - Otherwise: go to IGNORE with no ACK.
- ACK: on the first scl_fall, sda_oe=1. On the next scl_fall (end of the 9th clock), sda_oe=0.
  - After an address ACK, go to DATA and set busy=1.
  - After a data ACK, go to DATA.
- DATA: shift 8 bits on scl_rise. On the 8th rise:
  - If rx_valid=0 or a transfer happens this cycle: load rx_data on the next cycle (rx_valid=1 on the cycle after the 8th rise is detected), set rx_first=first_flag, clear first_flag, go to ACK.
  - Otherwise (holding register full): byte dropped, overrun=1, go to NACK.
- NACK: sda_oe stays 0 through the 9th clock. On the second scl_fall go to IGNORE; the controller must STOP or START.
- IGNORE: sda_oe=0; wait for START or STOP.

first_flag:
- Set on an address match; cleared when the first data byte loads.

Holding register:
- rx_valid clears on a transfer unless a new load happens in the same cycle. A simultaneous transfer and load leaves rx_valid=1 with the new data.
- rx_data does not change while rx_valid=1 without a transfer.

overrun:
- Cleared only by rst.

Glitches:
- SCL edges occurring during ACK/NACK are counted only as described above.
- An SDA change while SCL is high in DATA is by definition START or STOP.

Reset mid-frame:
- Immediate return to IDLE; sda_oe=0 asynchronously.

Test Plan:
1. rst pulse high with sda_in=scl_in=1 -> all outputs 0; an idle bus for 100 cycles leaves state IDLE and sda_oe=0.
2. START, address 0x42+W, byte 0xA5, STOP with rx_ready=1:
   - sda_oe=1 during both 9th clocks.
   - rx_data=0xA5 with rx_valid=1 and rx_first=1 for one cycle.
   - frame_end pulses once after STOP; busy is 0 afterwards.
3. START, address 0x43+W, byte 0xFF -> sda_oe never asserts, rx_valid stays 0, frame_end does not pulse.
4. Address 0x42+W, bytes 0x11, 0x22, 0x33, rx_ready=0 throughout:
   - rx_data=0x11 held with rx_first=1.
   - 0x22 is NACKed (sda_oe=0 on its 9th clock) and overrun=1.
   - 0x33 is ignored; rx_data is still 0x11.
5. Address 0x42+W, byte 0x10, repeated START, address 0x42+W, byte 0x20, STOP, rx_ready=1:
   - frame_end pulses at the repeated START.
   - Both bytes are delivered, each with rx_first=1.
6. Assert rst during the ACK low phase after the address -> sda_oe drops asynchronously. A following full frame with byte 0x5A is received normally.
